// File: rtl/rom_arbiter.sv
// Shares one synchronous ROM between a fixed-latency video fetch path and a
// req/ack background requester; in-flight reads carry an owner tag.
module rom_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8,
  parameter int ROM_LAT    = 1,
  parameter int STARVE_LIM = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              bg_req,
  input  logic [ADDR_W-1:0] bg_addr,
  output logic              bg_ack,
  output logic [DATA_W-1:0] bg_data,
  output logic              bg_valid,
  output logic              bg_starve,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int CNT_RAW = $clog2(STARVE_LIM + 1);
  localparam int CNT_W   = (CNT_RAW < 11) ? 11 : CNT_RAW;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ROM_LAT:0]  tag_v_q, tag_v_d;
  logic [ROM_LAT:0]  tag_o_q, tag_o_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic [DATA_W-1:0] bg_data_q, bg_data_d;
  logic              vid_valid_q, vid_valid_d;
  logic              bg_valid_q, bg_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              starve_q, starve_d;
  logic              ret_v, ret_o;

  // Video always wins; reset masks the grant so no read is issued under reset.
  assign bg_ack = bg_req & ~vid_req & ~rst;

  always_comb begin
    rom_addr_d = rom_addr_q;
    if (vid_req)     rom_addr_d = vid_addr;
    else if (bg_req) rom_addr_d = bg_addr;

    // Tag owner: 0 = video, 1 = background.
    tag_v_d    = tag_v_q << 1;
    tag_v_d[0] = vid_req | bg_req;
    tag_o_d    = tag_o_q << 1;
    tag_o_d[0] = ~vid_req & bg_req;

    ret_v = tag_v_q[ROM_LAT];
    ret_o = tag_o_q[ROM_LAT];

    vid_valid_d = ret_v & ~ret_o;
    bg_valid_d  = ret_v & ret_o;
    vid_data_d  = vid_valid_d ? rom_data : vid_data_q;
    bg_data_d   = bg_valid_d ? rom_data : bg_data_q;

    cnt_d = '0;
    if (bg_req && !bg_ack) cnt_d = (cnt_q >= LIM) ? cnt_q : cnt_q + 1'b1;
    starve_d = (cnt_d >= LIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q  <= '0;
      tag_v_q     <= '0;
      tag_o_q     <= '0;
      vid_data_q  <= '0;
      bg_data_q   <= '0;
      vid_valid_q <= 1'b0;
      bg_valid_q  <= 1'b0;
      cnt_q       <= '0;
      starve_q    <= 1'b0;
    end else begin
      rom_addr_q  <= rom_addr_d;
      tag_v_q     <= tag_v_d;
      tag_o_q     <= tag_o_d;
      vid_data_q  <= vid_data_d;
      bg_data_q   <= bg_data_d;
      vid_valid_q <= vid_valid_d;
      bg_valid_q  <= bg_valid_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign vid_data  = vid_data_q;
  assign vid_valid = vid_valid_q;
  assign bg_data   = bg_data_q;
  assign bg_valid  = bg_valid_q;
  assign bg_starve = starve_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: behavioural ROM, scoreboard queue of
// expected returns, per-cycle checks of every output.
module tb_rom_arbiter;

  localparam int LIM = 1024;

  logic        clk = 1'b0;
  logic        rst, vid_req, bg_req;
  logic [10:0] vid_addr, bg_addr, rom_addr;
  logic [7:0]  vid_data, bg_data, rom_data;
  logic        vid_valid, bg_valid, bg_ack, bg_starve;

  rom_arbiter dut (
    .clk(clk), .rst(rst),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .bg_req(bg_req), .bg_addr(bg_addr), .bg_ack(bg_ack), .bg_data(bg_data),
    .bg_valid(bg_valid), .bg_starve(bg_starve),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    int t;
    t = int'(a) * 37 + (int'(a) >> 3) + 5;
    return t[7:0];
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  typedef struct {
    int         due;
    logic       owner;
    logic [7:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          tests = 0;
  int          fails = 0;
  int          cyc_n = 0;
  int          cnt_m = 0;
  logic [10:0] exp_rom = '0;
  logic [7:0]  exp_vd = '0, exp_bd = '0;
  logic        exp_vv = 1'b0, exp_bv = 1'b0, exp_st = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc_n, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the combinational grant, advance,
  // update the model and check all registered outputs.
  task automatic cyc(input logic r, input logic vr, input logic [10:0] va,
                     input logic br, input logic [10:0] ba);
    logic ack_m;
    rst = r; vid_req = vr; vid_addr = va; bg_req = br; bg_addr = ba;
    #1;
    ack_m = br & ~vr & ~r;
    chk("bg_ack", 32'(bg_ack), 32'(ack_m));
    @(posedge clk);
    cyc_n++;
    if (r) begin
      sb.delete();
      exp_rom = '0; exp_vd = '0; exp_bd = '0;
      exp_vv = 1'b0; exp_bv = 1'b0; exp_st = 1'b0; cnt_m = 0;
    end else begin
      exp_vv = 1'b0; exp_bv = 1'b0;
      if (sb.size() > 0 && sb[0].due == cyc_n) begin
        e = sb.pop_front();
        if (e.owner) begin exp_bv = 1'b1; exp_bd = e.data; end
        else         begin exp_vv = 1'b1; exp_vd = e.data; end
      end
      if (vr) begin
        exp_rom = va;
        sb.push_back('{due: cyc_n + 2, owner: 1'b0, data: rom_fn(va)});
      end else if (br) begin
        exp_rom = ba;
        sb.push_back('{due: cyc_n + 2, owner: 1'b1, data: rom_fn(ba)});
      end
      if (br && !ack_m) cnt_m = (cnt_m >= LIM) ? cnt_m : cnt_m + 1;
      else              cnt_m = 0;
      exp_st = (cnt_m >= LIM);
    end
    #1;
    chk("rom_addr",  32'(rom_addr),  32'(exp_rom));
    chk("vid_valid", 32'(vid_valid), 32'(exp_vv));
    chk("vid_data",  32'(vid_data),  32'(exp_vd));
    chk("bg_valid",  32'(bg_valid),  32'(exp_bv));
    chk("bg_data",   32'(bg_data),   32'(exp_bd));
    chk("bg_starve", 32'(bg_starve), 32'(exp_st));
  endtask

  initial begin
    rst = 1'b1; vid_req = 1'b0; bg_req = 1'b0; vid_addr = '0; bg_addr = '0;
    @(posedge clk);
    #1;

    // reset then idle
    for (int i = 0; i < 40; i++) cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0);

    // video streaming 0..799
    for (int i = 0; i < 800; i++) cyc(0, 1, 11'(i), 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);

    // single background read
    cyc(0, 0, 0, 1, 11'h155);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);

    // background starved by 1100 video cycles, then served
    for (int i = 0; i < 1100; i++) cyc(0, 1, 11'(i & 7), 1, 11'h7FF);
    cyc(0, 0, 0, 1, 11'h7FF);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);

    // alternating owners
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) cyc(0, 1, 11'h010, 0, 0);
      else            cyc(0, 0, 0, 1, 11'h020);
    end
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);

    // reset with reads in flight; bg_req held through reset
    cyc(0, 1, 11'h0AA, 0, 0);
    cyc(0, 1, 11'h0BB, 0, 0);
    cyc(1, 0, 0, 1, 11'h033);
    cyc(0, 0, 0, 1, 11'h033);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 11'h0CC, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
